// File: rtl/shift_pkg.sv
// ---------------------------------------------------------------------------
// shift_pkg
// Definitions shared by the serial shift-register family: the serial
// deserializer (shift_deser) and its matching transmitter.
//   shift_state_e : two-state frame FSM encoding (IDLE, SHIFT)
//   DIR_LEFT      : first bit on the wire is the MSB
//   DIR_RIGHT     : first bit on the wire is the LSB
//   clog2()       : ceiling log2, used to size bit counters
// ---------------------------------------------------------------------------
package shift_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } shift_state_e;

    localparam string DIR_LEFT  = "LEFT";
    localparam string DIR_RIGHT = "RIGHT";

    // Smallest n such that 2**n >= value; never returns less than 1 so a
    // counter built from it is always at least one bit wide.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/shift_deser.sv
// ---------------------------------------------------------------------------
// shift_deser
// Serial-to-parallel deserializer with a one-deep output buffer.
//
// Parameters
//   SHIFT_WIDTH     : data bits per frame (2..32)
//   SHIFT_DIRECTION : "LEFT"  -> first received bit lands in the MSB
//                     "RIGHT" -> first received bit lands in the LSB
// Ports
//   clk        in   rising-edge clock
//   sclr       in   synchronous active-high reset
//   enable     in   bit strobe; start/shiftin sampled only when high
//   start      in   frame-start marker, sampled with the first bit
//   shiftin    in   serial data
//   q          out  received parallel word
//   q_valid    out  q holds an unconsumed word
//   q_ready    in   consumer accepts q when q_valid && q_ready
//   busy       out  a frame is in progress
//   overrun    out  sticky: a completed frame was dropped
//   parity_err out  parity of the word in q was wrong
//
// Build option
//   SHIFT_DESER_PARITY_EN : when defined, each frame carries one trailing
//   even-parity bit; the frame completes on that bit and parity_err is
//   loaded alongside q. When undefined, parity_err is tied to 0.
// ---------------------------------------------------------------------------
module shift_deser
    import shift_pkg::*;
#(
    parameter int    SHIFT_WIDTH     = 8,
    parameter string SHIFT_DIRECTION = "LEFT"
) (
    input  logic                   clk,
    input  logic                   sclr,
    input  logic                   enable,
    input  logic                   start,
    input  logic                   shiftin,
    output logic [SHIFT_WIDTH-1:0] q,
    output logic                   q_valid,
    input  logic                   q_ready,
    output logic                   busy,
    output logic                   overrun,
    output logic                   parity_err
);

    localparam bit IS_LEFT = (SHIFT_DIRECTION == DIR_LEFT);
    localparam int CNT_W   = clog2(SHIFT_WIDTH + 1);

`ifdef SHIFT_DESER_PARITY_EN
    localparam int FRAME_LEN = SHIFT_WIDTH + 1;
    localparam logic [CNT_W-1:0] DATA_CNT = CNT_W'(SHIFT_WIDTH);
`else
    localparam int FRAME_LEN = SHIFT_WIDTH;
`endif

    // cnt holds the number of bits already captured, so the frame's final
    // bit arrives while cnt equals FRAME_LEN-1.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

    shift_state_e           state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [SHIFT_WIDTH-1:0] sreg_q, sreg_d;
    logic [SHIFT_WIDTH-1:0] q_q, q_d;
    logic                   q_valid_q, q_valid_d;
    logic                   overrun_q, overrun_d;

    logic [SHIFT_WIDTH-1:0] sreg_shift;
    logic [SHIFT_WIDTH-1:0] done_word;
    logic                   take_data;
    logic                   frame_done;

`ifdef SHIFT_DESER_PARITY_EN
    logic                   par_q, par_d;
    logic                   parity_err_q, parity_err_d;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sreg_d     = sreg_q;
        q_d        = q_q;
        q_valid_d  = q_valid_q;
        overrun_d  = overrun_q;
        take_data  = 1'b0;
        frame_done = 1'b0;

        sreg_shift = IS_LEFT ? {sreg_q[SHIFT_WIDTH-2:0], shiftin}
                             : {shiftin, sreg_q[SHIFT_WIDTH-1:1]};

        unique case (state_q)
            IDLE: begin
                if (enable && start) begin
                    state_d   = SHIFT;
                    cnt_d     = CNT_W'(1);
                    take_data = 1'b1;
                end
            end
            SHIFT: begin
                // start is deliberately ignored here: no mid-frame resync.
                if (enable) begin
                    if (cnt_q == LAST_CNT) begin
                        state_d    = IDLE;
                        cnt_d      = '0;
                        frame_done = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
`ifdef SHIFT_DESER_PARITY_EN
                    // The trailing parity bit is checked, not stored.
                    take_data = (cnt_q < DATA_CNT);
`else
                    take_data = 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        if (take_data) begin
            sreg_d = sreg_shift;
        end

`ifdef SHIFT_DESER_PARITY_EN
        // Running XOR of the data bits; restarts on the frame's first bit.
        par_d        = par_q;
        parity_err_d = parity_err_q;
        if (take_data) begin
            par_d = (state_q == IDLE) ? shiftin : (par_q ^ shiftin);
        end
        // All data bits already sit in sreg when the parity bit arrives.
        done_word = sreg_q;
`else
        // The final data bit is still on shiftin, so use the shifted value.
        done_word = sreg_shift;
`endif

        // A handshake frees the buffer; a completing frame may refill it in
        // the same cycle, otherwise it is dropped and flagged as overrun.
        if (q_valid_q && q_ready) begin
            q_valid_d = 1'b0;
        end
        if (frame_done) begin
            if (!q_valid_q || q_ready) begin
                q_d       = done_word;
                q_valid_d = 1'b1;
`ifdef SHIFT_DESER_PARITY_EN
                parity_err_d = par_q ^ shiftin;
`endif
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // State registers; sclr has priority over every other input.
    always_ff @(posedge clk) begin
        if (sclr) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sreg_q    <= '0;
            q_q       <= '0;
            q_valid_q <= 1'b0;
            overrun_q <= 1'b0;
`ifdef SHIFT_DESER_PARITY_EN
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sreg_q    <= sreg_d;
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
            overrun_q <= overrun_d;
`ifdef SHIFT_DESER_PARITY_EN
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign q       = q_q;
    assign q_valid = q_valid_q;
    assign overrun = overrun_q;
    assign busy    = (state_q == SHIFT);

`ifdef SHIFT_DESER_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule
